// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving one 2:1 mux into a single-entry
// registered output buffer, with a per-owner burst limit under contention.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             selo,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic             last_a_reg, last_a_next;  // 1 when A was the most recent grantee
  logic             selo_reg, selo_next;
  logic             busy_reg;
  logic [WIDTH-1:0] data_reg, mux_data;
  logic             valid_reg;
  logic             acc;
  logic             grant_a, grant_b;

  assign acc     = ~valid_reg | out_ready;
  assign cnt_inc = (cnt_reg < MAX_CNT) ? cnt_reg + ONE_CNT : MAX_CNT;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    last_a_next = last_a_reg;
    selo_next   = selo_reg;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    if (acc && !rst) begin
      unique case (state_reg)
        IDLE: begin
          if (req_a && (!req_b || !last_a_reg)) grant_a = 1'b1;
          else if (req_b)                       grant_b = 1'b1;
        end
        OWN_A: begin
          if (req_a && ((cnt_reg < MAX_CNT) || !req_b)) grant_a = 1'b1;
          else if (req_b)                               grant_b = 1'b1;
          else begin
            state_next = IDLE;
            selo_next  = 1'b0;
            cnt_next   = '0;
          end
        end
        OWN_B: begin
          if (req_b && ((cnt_reg < MAX_CNT) || !req_a)) grant_b = 1'b1;
          else if (req_a)                               grant_a = 1'b1;
          else begin
            state_next = IDLE;
            selo_next  = 1'b0;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
      // A repeat grant extends the burst; a fresh grant restarts it at one beat.
      if (grant_a) begin
        state_next  = OWN_A;
        selo_next   = 1'b1;
        last_a_next = 1'b1;
        cnt_next    = (state_reg == OWN_A) ? cnt_inc : ONE_CNT;
      end
      if (grant_b) begin
        state_next  = OWN_B;
        selo_next   = 1'b0;
        last_a_next = 1'b0;
        cnt_next    = (state_reg == OWN_B) ? cnt_inc : ONE_CNT;
      end
    end
  end

  // The mux follows the select being granted this cycle, not the registered one.
  assign mux_data = selo_next ? data_a : data_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_a_reg <= 1'b0;
      selo_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_a_reg <= last_a_next;
      selo_reg   <= selo_next;
      busy_reg   <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (grant_a || grant_b) begin
      data_reg  <= mux_data;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign ack_a     = grant_a;
  assign ack_b     = grant_b;
  assign selo      = selo_reg;
  assign busy      = busy_reg;
  assign out_data  = data_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scenario bench for mux2_rr_arbiter: tasks check grants inline, a scoreboard
// queue holds granted words and is drained against delivered output words.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       ack_a, ack_b, selo, out_valid, busy;
  logic [7:0] out_data;

  int         checks = 0;
  int         errors = 0;
  int         na = 0, nb = 0;
  logic [7:0] q[$];
  logic [7:0] exp_w;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .selo(selo), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard drain: every accepted output word must match the oldest granted word.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL deliver: got word %h, none expected", out_data);
      end else begin
        exp_w = q.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL deliver: got %h want %h", out_data, exp_w);
        end else
          $display("deliver %h ok", out_data);
      end
    end
  end

  task automatic drive(input logic ra, input logic rb, input logic rdy);
    @(negedge clk);
    req_a     = ra;
    req_b     = rb;
    out_ready = rdy;
    data_a    = 8'hA0 | 8'(na & 15);
    data_b    = 8'hB0 | 8'(nb & 15);
    #1;
  endtask

  task automatic commit(input logic ea, input logic eb);
    if (ea) begin q.push_back(data_a); na++; end
    if (eb) begin q.push_back(data_b); nb++; end
  endtask

  task automatic test_reset();
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b%b want 00", ack_a, ack_b);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || selo !== 1'b0) begin
      errors++; $display("FAIL reset_regs: valid/busy/selo got %b%b%b want 000", out_valid, busy, selo);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", out_data);
    end
    $display("reset state checked");
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single();
    na = 5;
    drive(1, 0, 1);
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++; $display("FAIL single_ack: got %b%b want 10", ack_a, ack_b);
    end
    commit(1, 0);
    drive(0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL single_out: valid %b data %h want 1 a5", out_valid, out_data);
    end
    checks++;
    if (selo !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_own: selo %b busy %b want 1 1", selo, busy);
    end
    drive(0, 0, 1);
    checks++;
    if (busy !== 1'b0 || selo !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy %b selo %b valid %b want 000", busy, selo, out_valid);
    end
    $display("single requester done");
  endtask

  task automatic test_tie_after_idle();
    drive(1, 1, 1);
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b1) begin
      errors++; $display("FAIL tie_after_a: got %b%b want 01", ack_a, ack_b);
    end
    commit(0, 1);
    drive(0, 0, 1);
    checks++;
    if (busy !== 1'b1 || selo !== 1'b0) begin
      errors++; $display("FAIL tie_own_b: busy %b selo %b want 1 0", busy, selo);
    end
    drive(0, 0, 1);
    $display("tie after idle done");
  endtask

  task automatic test_contention();
    logic ea, prev_a;
    prev_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 1);
      ea = ((i / 4) % 2 == 0);
      checks++;
      if (ack_a !== ea || ack_b !== !ea) begin
        errors++; $display("FAIL contention[%0d]: ack got %b%b want %b%b", i, ack_a, ack_b, ea, !ea);
      end else
        $display("contention beat %0d grant %s", i, ea ? "A" : "B");
      if (i > 0) begin
        checks++;
        if (selo !== prev_a) begin
          errors++; $display("FAIL contention_selo[%0d]: got %b want %b", i, selo, prev_a);
        end
      end
      commit(ea, !ea);
      prev_a = ea;
    end
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask

  task automatic test_backpressure();
    drive(1, 0, 1);
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL bp_start0: ack_a got %b want 1", ack_a); end
    commit(1, 0);
    drive(1, 0, 1);
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL bp_start1: ack_a got %b want 1", ack_a); end
    commit(1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      checks++;
      if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
        errors++; $display("FAIL bp_stall[%0d]: ack got %b%b want 00", i, ack_a, ack_b);
      end
      checks++;
      if (out_valid !== 1'b1 || q.size() != 1 || out_data !== q[0]) begin
        errors++; $display("FAIL bp_hold[%0d]: valid %b data %h want held word", i, out_valid, out_data);
      end else
        $display("stall %0d holding %h", i, out_data);
    end
    drive(1, 0, 1);
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL bp_resume: ack_a got %b want 1", ack_a); end
    commit(1, 0);
    // Third beat now; one more A beat is allowed before B must be served.
    drive(1, 1, 1);
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++; $display("FAIL bp_count4: ack got %b%b want 10", ack_a, ack_b);
    end
    commit(1, 0);
    drive(1, 1, 1);
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b1) begin
      errors++; $display("FAIL bp_forced: ack got %b%b want 01", ack_a, ack_b);
    end
    commit(0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask

  task automatic test_owner_drop();
    drive(1, 0, 1);
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL drop_grant: ack_a got %b want 1", ack_a); end
    commit(1, 0);
    drive(0, 0, 1);
    checks++;
    if (busy !== 1'b1 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      errors++; $display("FAIL drop_own: busy %b ack %b%b want 1 00", busy, ack_a, ack_b);
    end
    drive(0, 0, 1);
    checks++;
    if (busy !== 1'b0 || selo !== 1'b0) begin
      errors++; $display("FAIL drop_idle: busy %b selo %b want 0 0", busy, selo);
    end
    for (int i = 0; i < 7; i++) begin
      logic ea;
      if (i < 2)       drive(1, 0, 1);
      else if (i == 2) drive(0, 1, 1);
      else             drive(1, 1, 1);
      ea = (i < 2) || (i == 6);
      checks++;
      if (ack_a !== ea || ack_b !== !ea) begin
        errors++; $display("FAIL drop_switch[%0d]: ack got %b%b want %b%b", i, ack_a, ack_b, ea, !ea);
      end else
        $display("switch beat %0d grant %s", i, ea ? "A" : "B");
      if (i == 3) begin
        checks++;
        if (selo !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL drop_switch_own: selo %b busy %b want 0 1", selo, busy);
        end
      end
      commit(ea, !ea);
    end
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 1, 1);
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b1) begin
      errors++; $display("FAIL mid_grant: ack got %b%b want 01", ack_a, ack_b);
    end
    commit(0, 1);
    drive(1, 1, 0);
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: ack %b%b valid %b busy %b want 00 1 1", ack_a, ack_b, out_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || selo !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: valid %b busy %b selo %b data %h want 0 0 0 00", out_valid, busy, selo, out_data);
    end
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ack: got %b%b want 00", ack_a, ack_b);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++; $display("FAIL mid_release_tie: ack got %b%b want 10", ack_a, ack_b);
    end else
      $display("post-reset tie granted A");
    commit(1, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_after_idle();
    test_contention();
    test_backpressure();
    test_owner_drop();
    test_reset_mid_burst();
    drive(0, 0, 1);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL final_drain: pending %0d valid %b want 0 0", q.size(), out_valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data mux between two requesters, A and B, and feeds the selected word into a single-entry registered output buffer.
- A three-state FSM owns the mux select.
- Round-robin tie-break plus a burst limit of MAX_BURST consecutive beats per owner when the other side is waiting.
- Sits between two producer channels and one downstream consumer that uses a valid/ready handshake.

Parameters:
- WIDTH, 8: data width of each input word and of the output word.
- MAX_BURST, 4: maximum consecutive beats granted to one owner while the other requester is asserting req; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_a  input  1  A has a word on data_a; held high until ack_a
- data_a  input  WIDTH  A's word; stable while req_a is high
- ack_a  output  1  combinational; high in the cycle data_a is captured at the next edge
- req_b  input  1  same as req_a, for B
- data_b  input  WIDTH  B's word
- ack_b  output  1  same as ack_a, for B
- selo  output  1  registered mux select; 1 = A is owner, 0 = B or idle
- out_data  output  WIDTH  registered output word
- out_valid  output  1  out_data holds an undelivered word
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready
- busy  output  1  registered; 1 when the FSM is in OWN_A or OWN_B

Behaviour:
- Reset (asynchronous, takes effect immediately when rst rises):
  - state=IDLE, selo=0, out_data=0, out_valid=0, busy=0, burst_cnt=0, last=B (so A wins the first tie).
  - ack_a and ack_b are 0 while rst is high.
- Any word in the output buffer is discarded on reset. Requesters keep req asserted and are re-served after reset releases.
- acc = ~out_valid | out_ready. No ack can be issued when acc=0. The FSM holds its state, counter and selo in that case.
- Capture: when ack_x=1, at the next edge out_data<=data_x and out_valid<=1. Otherwise, if out_ready && out_valid, out_valid<=0.
  - A capture and a drain in the same cycle keep out_valid=1 with the new word. This gives back-to-back throughput of 1 word/cycle.
- Latency: req asserted with acc=1 and grant won gives ack in the same cycle, and out_valid one cycle later.
- FSM states: IDLE, OWN_A, OWN_B. burst_cnt has width clog2(MAX_BURST)+1 and saturates at MAX_BURST.
- IDLE, when acc:
  - Only one req set: grant that requester.
  - Both set: grant the side opposite to last.
  - On grant: ack it, next state OWN_x, burst_cnt<=1, last<=x, selo<=(x==A).
  - No req: stay IDLE.
- OWN_A, when acc (OWN_B is symmetric):
  - req_a && (burst_cnt<MAX_BURST || !req_b): ack_a, burst_cnt<=sat(burst_cnt+1), stay.
  - Else if req_b: ack_b, go to OWN_B, burst_cnt<=1, last<=B, selo<=0.
  - Else (no req): go to IDLE, no ack, selo<=0, burst_cnt<=0.
- Forced switch: when burst_cnt==MAX_BURST and the other side requests, ownership transfers on that acceptance cycle. The limited owner never gets beat MAX_BURST+1 while the other side waits.
- Mutual exclusion: at most one of ack_a, ack_b is high in any cycle.
- With MAX_BURST=1 the arbiter strictly alternates under contention.
- Backpressure: if out_ready stays 0 with out_valid=1, no further ack is issued and out_data is held stable.

Test Plan:
- Reset: assert rst mid-burst with out_valid=1 → out_valid, busy, selo go to 0 immediately; the first tie after release grants A.
- Single requester: req_a=1, data_a=8'hA5, out_ready=1 → ack_a same cycle; out_data=8'hA5 with out_valid=1 on the next cycle; selo=1, busy=1.
- Contention, MAX_BURST=4: req_a and req_b held high, out_ready=1 → ack pattern A,A,A,A,B,B,B,B,A…; selo toggles every 4 cycles.
- Backpressure: A streaming, out_ready=0 for 3 cycles → ack_a=0 during the stall; out_data stable; the counter does not advance; the stream resumes on the cycle out_ready returns to 1.
- Owner drops: OWN_A with req_a falling and req_b=0 → IDLE next cycle, busy=0. If req_b=1 instead → immediate switch to B, burst_cnt=1.
- Tie after idle: last=A, both reqs rise together → B granted first.
